// File: rtl/avl_mem_responder_pkg.sv
// Shared widths, FSM state type and counter sizing helper for the Avalon-MM
// memory responder.
package avl_mem_pkg;

    localparam int AVL_ADDR_W = 24;
    localparam int AVL_DATA_W = 64;
    localparam int AVL_BE_W   = 8;
    localparam int AVL_SIZE_W = 7;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        READY = 2'd1,
        STALL = 2'd2
    } state_t;

    // Width of a down-counter that must hold the value n (never zero bits wide).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/avl_mem_responder_if.sv
// Avalon-MM local-interface bundle between the command generator (master)
// and the memory responder (slave).
interface avl_mem_if;
    import avl_mem_pkg::*;

    logic                  avl_ready;
    logic                  avl_burstbegin;
    logic [AVL_ADDR_W-1:0] avl_addr;
    logic [AVL_DATA_W-1:0] avl_wdata;
    logic [AVL_BE_W-1:0]   avl_be;
    logic                  avl_read_req;
    logic                  avl_write_req;
    logic [AVL_SIZE_W-1:0] avl_size;
    logic [AVL_DATA_W-1:0] avl_rdata;
    logic                  avl_rdata_valid;

    modport slave (
        input  avl_burstbegin, avl_addr, avl_wdata, avl_be,
               avl_read_req, avl_write_req, avl_size,
        output avl_ready, avl_rdata, avl_rdata_valid
    );

    modport master (
        output avl_burstbegin, avl_addr, avl_wdata, avl_be,
               avl_read_req, avl_write_req, avl_size,
        input  avl_ready, avl_rdata, avl_rdata_valid
    );

endinterface

// File: rtl/avl_read_pipe.sv
// Fixed-latency read return pipe: READ_LATENCY stages of {valid, data}.
// The final data stage only updates on a valid beat, so the output holds.
module avl_read_pipe #(
    parameter int READ_LATENCY = 4,
    parameter int DATA_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              v_chain [READ_LATENCY+1];
    logic [DATA_W-1:0] d_chain [READ_LATENCY+1];

    assign v_chain[0] = in_valid;
    assign d_chain[0] = in_data;

    for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
        logic              v_q;
        logic [DATA_W-1:0] d_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) v_q <= 1'b0;
            else       v_q <= v_chain[i];
        end

        // NOTE: inner data stages carry no reset (qualified by valid); only the
        // output stage is cleared so the visible read data starts at zero.
        if (i == READ_LATENCY - 1) begin : g_out
            always_ff @(posedge clk or posedge reset) begin
                if (reset)           d_q <= '0;
                else if (v_chain[i]) d_q <= d_chain[i];
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (v_chain[i]) d_q <= d_chain[i];
            end
        end

        assign v_chain[i+1] = v_q;
        assign d_chain[i+1] = d_q;
    end

    assign out_valid = v_chain[READ_LATENCY];
    assign out_data  = d_chain[READ_LATENCY];

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM responder standing in for a DDR3 controller local interface:
// init/cal status sequence, single-word commands, on-chip backing store.
module avl_mem_responder
    import avl_mem_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 10,
    parameter int INIT_CYCLES   = 16,
    parameter int CAL_FAIL      = 0,
    parameter int READ_LATENCY  = 4,
    parameter int STALL_CYCLES  = 0
) (
    input  logic     clk,
    input  logic     reset,
    avl_mem_if.slave avl,
    output logic     ddr3_init_done,
    output logic     ddr3_cal_success,
    output logic     ddr3_cal_fail,
    output logic     protocol_error
);

    localparam int INIT_W  = cnt_width(INIT_CYCLES);
    localparam int STALL_W = cnt_width(STALL_CYCLES);

    state_t                   state;
    logic [INIT_W-1:0]        init_cnt;
    logic [STALL_W-1:0]       stall_cnt;
    logic                     size_ok;
    logic                     any_req;
    logic                     accept;
    logic                     illegal;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic [AVL_DATA_W-1:0]    rd_word;
    logic                     unused_inputs;

    // Burstbegin carries no information for single-word commands; upper
    // address bits alias onto the backing array.
    assign unused_inputs = ^{avl.avl_burstbegin, avl.avl_addr[AVL_ADDR_W-1:MEM_ADDR_BITS]};

    assign idx     = avl.avl_addr[MEM_ADDR_BITS-1:0];
    assign size_ok = (avl.avl_size == AVL_SIZE_W'(1));
    assign any_req = avl.avl_read_req | avl.avl_write_req;
    assign accept  = avl.avl_ready & (avl.avl_read_req ^ avl.avl_write_req) & size_ok;
    assign illegal = avl.avl_ready &
                     ((avl.avl_read_req & avl.avl_write_req) | (any_req & ~size_ok));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= INIT;
            init_cnt         <= INIT_W'(INIT_CYCLES);
            stall_cnt        <= '0;
            avl.avl_ready    <= 1'b0;
            ddr3_init_done   <= 1'b0;
            ddr3_cal_success <= 1'b0;
            ddr3_cal_fail    <= 1'b0;
            protocol_error   <= 1'b0;
        end else begin
            if (illegal) protocol_error <= 1'b1;

            case (state)
                INIT: begin
                    // With CAL_FAIL the counter parks at zero and ready never rises.
                    if (init_cnt != '0) begin
                        init_cnt <= init_cnt - INIT_W'(1);
                        if (init_cnt == INIT_W'(1)) begin
                            ddr3_init_done   <= 1'b1;
                            ddr3_cal_success <= (CAL_FAIL == 0);
                            ddr3_cal_fail    <= (CAL_FAIL != 0);
                            if (CAL_FAIL == 0) begin
                                state         <= READY;
                                avl.avl_ready <= 1'b1;
                            end
                        end
                    end
                end
                READY: begin
                    if (accept && (STALL_CYCLES > 0)) begin
                        state         <= STALL;
                        avl.avl_ready <= 1'b0;
                        stall_cnt     <= STALL_W'(STALL_CYCLES);
                    end
                end
                STALL: begin
                    stall_cnt <= stall_cnt - STALL_W'(1);
                    if (stall_cnt == STALL_W'(1)) begin
                        state         <= READY;
                        avl.avl_ready <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // NOTE: the backing store has no reset; its contents survive a reset and
    // unwritten words read back as undefined.
    logic [AVL_DATA_W-1:0] mem [2**MEM_ADDR_BITS];

    always_ff @(posedge clk) begin
        if (accept && avl.avl_write_req) begin
            for (int i = 0; i < AVL_BE_W; i++) begin
                if (avl.avl_be[i]) mem[idx][i*8 +: 8] <= avl.avl_wdata[i*8 +: 8];
            end
        end
    end

    assign rd_word = mem[idx];

    avl_read_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (AVL_DATA_W)
    ) u_read_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept & avl.avl_read_req),
        .in_data   (rd_word),
        .out_valid (avl.avl_rdata_valid),
        .out_data  (avl.avl_rdata)
    );

endmodule

// File: tb/tb_avl_mem_responder.sv
// Directed bench for avl_mem_responder: three instances (default, cal-fail,
// two-cycle stall) sharing clock and reset, read data checked via scoreboard.
module tb_avl_mem_responder;
    import avl_mem_pkg::*;

    localparam int LAT = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t        q_def[$];
    exp_t        q_stall[$];
    logic [63:0] model [int];

    avl_mem_if bus_def ();
    avl_mem_if bus_fail ();
    avl_mem_if bus_stall ();

    logic def_done, def_succ, def_cf, def_perr;
    logic fl_done, fl_succ, fl_cf, fl_perr;
    logic st_done, st_succ, st_cf, st_perr;

    avl_mem_responder u_def (
        .clk(clk), .reset(reset), .avl(bus_def),
        .ddr3_init_done(def_done), .ddr3_cal_success(def_succ),
        .ddr3_cal_fail(def_cf), .protocol_error(def_perr)
    );

    avl_mem_responder #(.CAL_FAIL(1)) u_fail (
        .clk(clk), .reset(reset), .avl(bus_fail),
        .ddr3_init_done(fl_done), .ddr3_cal_success(fl_succ),
        .ddr3_cal_fail(fl_cf), .protocol_error(fl_perr)
    );

    avl_mem_responder #(.STALL_CYCLES(2)) u_stall (
        .clk(clk), .reset(reset), .avl(bus_stall),
        .ddr3_init_done(st_done), .ddr3_cal_success(st_succ),
        .ddr3_cal_fail(st_cf), .protocol_error(st_perr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read-return monitors: every valid beat must match the oldest expectation.
    always @(negedge clk) begin
        if (bus_def.avl_rdata_valid === 1'b1) begin
            if (q_def.size() == 0) begin
                check("def_extra_valid", 64'(bus_def.avl_rdata_valid), 64'd0);
            end else begin
                exp_t e;
                e = q_def.pop_front();
                check("def_rdata", bus_def.avl_rdata, e.data);
                check("def_rd_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (bus_stall.avl_rdata_valid === 1'b1) begin
            if (q_stall.size() == 0) begin
                check("stall_extra_valid", 64'(bus_stall.avl_rdata_valid), 64'd0);
            end else begin
                exp_t e;
                e = q_stall.pop_front();
                check("stall_rdata", bus_stall.avl_rdata, e.data);
                check("stall_rd_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic idle_all();
        bus_def.avl_read_req    = 1'b0;  bus_def.avl_write_req   = 1'b0;
        bus_def.avl_size        = 7'd1;  bus_def.avl_burstbegin  = 1'b0;
        bus_stall.avl_read_req  = 1'b0;  bus_stall.avl_write_req = 1'b0;
        bus_stall.avl_size      = 7'd1;  bus_stall.avl_burstbegin = 1'b0;
        bus_fail.avl_read_req   = 1'b0;  bus_fail.avl_write_req  = 1'b0;
        bus_fail.avl_size       = 7'd1;  bus_fail.avl_burstbegin = 1'b0;
        bus_fail.avl_addr       = '0;    bus_fail.avl_wdata      = '0;
        bus_fail.avl_be         = '0;
    endtask

    task automatic init_check();
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check("preinit_def",   {def_done, def_succ, def_cf, bus_def.avl_ready},   64'h0);
            check("preinit_fail",  {fl_done, fl_succ, fl_cf, bus_fail.avl_ready},     64'h0);
            check("preinit_stall", {st_done, st_succ, st_cf, bus_stall.avl_ready},    64'h0);
        end
        @(negedge clk);
        check("init_def",   {def_done, def_succ, def_cf, bus_def.avl_ready}, 64'b1101);
        check("init_fail",  {fl_done, fl_succ, fl_cf, bus_fail.avl_ready},   64'b1010);
        check("init_stall", {st_done, st_succ, st_cf, bus_stall.avl_ready},  64'b1101);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q_def.delete();
        q_stall.delete();
        idle_all();
        #1;
        check("rst_def_valid", 64'(bus_def.avl_rdata_valid), 64'd0);
        check("rst_def_perr", 64'(def_perr), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_def_ready", 64'(bus_def.avl_ready), 64'd0);
        check("rst_def_rdata", bus_def.avl_rdata, 64'd0);
        check("rst_def_status", {def_done, def_succ, def_cf}, 64'd0);
        reset = 1'b0;
        init_check();
    endtask

    task automatic def_write(input logic [23:0] addr, input logic [63:0] data, input logic [7:0] be);
        check("def_ready_wr", 64'(bus_def.avl_ready), 64'd1);
        bus_def.avl_addr = addr;  bus_def.avl_wdata = data;  bus_def.avl_be = be;
        bus_def.avl_size = 7'd1;  bus_def.avl_read_req = 1'b0;  bus_def.avl_write_req = 1'b1;
        @(negedge clk);
    endtask

    task automatic def_read(input logic [23:0] addr, input logic [63:0] exp_data);
        exp_t e;
        check("def_ready_rd", 64'(bus_def.avl_ready), 64'd1);
        bus_def.avl_addr = addr;  bus_def.avl_size = 7'd1;
        bus_def.avl_read_req = 1'b1;  bus_def.avl_write_req = 1'b0;
        e.data = exp_data;
        e.cyc  = 32'(cyc + 1 + LAT - 1);
        q_def.push_back(e);
        @(negedge clk);
    endtask

    task automatic def_raw(input logic rd, input logic wr, input logic [23:0] addr,
                           input logic [63:0] data, input logic [6:0] size);
        bus_def.avl_addr = addr;  bus_def.avl_wdata = data;  bus_def.avl_be = 8'hff;
        bus_def.avl_size = size;  bus_def.avl_read_req = rd;  bus_def.avl_write_req = wr;
        @(negedge clk);
    endtask

    // Presents a command to the stalling instance and holds it until accepted.
    task automatic stall_cmd(input logic wr, input logic [23:0] addr, input logic [63:0] data);
        int   n = 0;
        exp_t e;
        bus_stall.avl_addr = addr;  bus_stall.avl_wdata = data;  bus_stall.avl_be = 8'hff;
        bus_stall.avl_size = 7'd1;  bus_stall.avl_read_req = ~wr;  bus_stall.avl_write_req = wr;
        while (bus_stall.avl_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_wait_bound", 64'(n < 20), 64'd1);
        if (wr) begin
            model[int'(addr[9:0])] = data;
        end else begin
            e.data = model[int'(addr[9:0])];
            e.cyc  = 32'(cyc + 1 + LAT - 1);
            q_stall.push_back(e);
        end
        @(negedge clk);
        check("stall_low1", 64'(bus_stall.avl_ready), 64'd0);
        @(negedge clk);
        check("stall_low2", 64'(bus_stall.avl_ready), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_def.size() != 0 || q_stall.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(q_def.size() + q_stall.size()), 64'd0);
    endtask

    initial begin
        logic seen_ready;
        bus_def.avl_addr = '0;  bus_def.avl_wdata = '0;  bus_def.avl_be = '0;
        bus_stall.avl_addr = '0;  bus_stall.avl_wdata = '0;  bus_stall.avl_be = '0;

        // Power-on reset and init sequence on all three instances.
        do_reset();

        // Calibration failure: ready never rises.
        seen_ready = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen_ready |= bus_fail.avl_ready;
        end
        check("fail_ready_low", 64'(seen_ready), 64'd0);
        check("fail_status_hold", {fl_done, fl_succ, fl_cf}, 64'b101);

        // Write then read on the very next edge, then byte enables with aliasing.
        def_write(24'h000005, 64'hdeadfadebabebeea, 8'hff);
        def_read (24'h000005, 64'hdeadfadebabebeea);
        def_write(24'h400005, 64'h1111111122222222, 8'h0f);
        def_read (24'h000005, 64'hdeadfade22222222);
        idle_all();
        drain();

        // Simultaneous read and write requests are rejected.
        check("perr_clear", 64'(def_perr), 64'd0);
        def_raw(1'b1, 1'b1, 24'h000005, 64'h0, 7'd1);
        check("perr_rw_both", 64'(def_perr), 64'd1);
        check("ready_after_illegal", 64'(bus_def.avl_ready), 64'd1);
        def_read(24'h000005, 64'hdeadfade22222222);
        idle_all();
        drain();

        // Alternating writes and reads through a two-cycle stall.
        for (int k = 0; k < 4; k++) begin
            stall_cmd(1'b1, 24'h000100 + 24'(k), 64'h0123456789abcdef + 64'(k) * 64'h1010101010101010);
            stall_cmd(1'b0, 24'h000100 + 24'(k), 64'h0);
        end
        idle_all();
        drain();
        check("stall_perr", 64'(st_perr), 64'd0);

        // Reset in the middle of a read burst drops in-flight data.
        def_read(24'h000005, 64'hdeadfade22222222);
        def_read(24'h000005, 64'hdeadfade22222222);
        def_read(24'h000005, 64'hdeadfade22222222);
        do_reset();
        repeat (LAT + 2) @(negedge clk);
        check("no_valid_after_reset", 64'(bus_def.avl_rdata_valid), 64'd0);

        // Oversized burst is rejected; memory survived the reset untouched.
        def_raw(1'b0, 1'b1, 24'h000005, 64'h0, 7'd2);
        check("perr_size2", 64'(def_perr), 64'd1);
        check("ready_after_size2", 64'(bus_def.avl_ready), 64'd1);
        def_read(24'h000005, 64'hdeadfade22222222);
        idle_all();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
